// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encoding and counter sizing.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle between a requester (master) and the serial adder (slave).
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  import serial_add_ctrl_pkg::*;

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_add_ctrl_full_adder_bit.sv
// One-bit combinational full-adder cell.
module full_adder_bit
  import serial_add_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: feeds one full-adder cell LSB first over
// WIDTH cycles with a registered carry, then pulses done for one cycle.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int unsigned CW = clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             w_co;

  full_adder_bit u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b ^ {WIDTH{bus.sub}};
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          // On the MSB cycle the carry flop already holds carry-into-MSB.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_cout  <= w_co;
            r_ovf   <= r_carry ^ w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and swept checks for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_pass;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: {ovf, cout, sum} from two separate widened additions.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    logic [7:0] bb;
    logic       c0;
    logic [8:0] full;
    logic [7:0] low;
    bb   = sub ? ~b : b;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, c0};
    low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, c0};
    return {low[7] ^ full[8], full[8], full[7:0]};
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic s, output logic [9:0] res,
                       output int unsigned nbusy, output logic got_done);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
    bus.sub = s;
    @(negedge clk);
    bus.start = 1'b0;
    nbusy = 0;
    got_done = 1'b0;
    res = '0;
    for (int unsigned i = 0; i < 20 && !got_done; i++) begin
      if (bus.busy) nbusy++;
      if (bus.done) begin
        got_done = 1'b1;
        res = {bus.ovf, bus.cout, bus.sum};
      end else begin
        @(negedge clk);
      end
    end
  endtask

  vec_t        vecs[10];
  logic [9:0]  res;
  logic [9:0]  exp10;
  int unsigned nb;
  logic        gd;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    vecs[0] = '{"add_5a_3c",  8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{"add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"add_cin",    8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{"sub_10_20",  8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{"sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{"add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{"sub_05_05",  8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{"add_80_80",  8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{"add_ff_ff1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{"sub_00_01",  8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    #3;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_sum",  32'(bus.sum), 0);
    check("rst_cout", 32'(bus.cout), 0);
    check("rst_ovf",  32'(bus.ovf), 0);
    // Start held across reset release must not be taken on that edge.
    bus.start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("rel_no_start", 32'(bus.busy), 0);

    for (int unsigned i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, res, nb, gd);
      check({vecs[i].name, "_done"}, 32'(gd), 1);
      check({vecs[i].name, "_busy"}, nb, W);
      check({vecs[i].name, "_sum"},  32'(res[7:0]), 32'(vecs[i].e_sum));
      check({vecs[i].name, "_cout"}, 32'(res[8]), 32'(vecs[i].e_cout));
      check({vecs[i].name, "_ovf"},  32'(res[9]), 32'(vecs[i].e_ovf));
      @(negedge clk);
      check({vecs[i].name, "_pulse"}, 32'(bus.done), 0);
      check({vecs[i].name, "_hold"},  32'(bus.sum), 32'(vecs[i].e_sum));
    end

    // start held high with operands changing every cycle
    begin
      int unsigned last_acc;
      int unsigned acc_cnt;
      int unsigned done_cnt;
      logic        prev_busy;
      logic [7:0]  pa;
      logic [7:0]  pb;
      logic [9:0]  pend;
      last_acc = 0; acc_cnt = 0; done_cnt = 0; prev_busy = 1'b0;
      pa = '0; pb = '0; pend = '0;
      bus.sub = 1'b0;
      bus.cin = 1'b0;
      for (int unsigned c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.busy && !prev_busy) begin
          if (acc_cnt > 0) check("hold_spacing", c - last_acc, 10);
          last_acc = c;
          acc_cnt++;
          pend = model(pa, pb, 1'b0, 1'b0);
        end
        if (bus.done) begin
          done_cnt++;
          check("hold_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'(pend));
        end
        prev_busy = bus.busy;
        pa = 8'(c * 3 + 1);
        pb = 8'(c * 29 + 5);
        bus.a = pa;
        bus.b = pb;
        bus.start = 1'b1;
      end
      bus.start = 1'b0;
      check("hold_accepts", acc_cnt, 4);
      check("hold_dones", done_cnt, 4);
    end

    // reset during the 4th RUN cycle
    @(negedge clk);
    @(negedge clk);
    bus.a = 8'h33; bus.b = 8'h44; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_busy_pre", 32'(bus.busy), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_sum",  32'(bus.sum), 0);
    check("abort_cout", 32'(bus.cout), 0);
    check("abort_ovf",  32'(bus.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int unsigned spurious;
      spurious = 0;
      repeat (10) begin
        @(negedge clk);
        if (bus.done || bus.busy) spurious++;
      end
      check("abort_quiet", spurious, 0);
    end
    do_op(8'hC8, 8'h64, 1'b0, 1'b1, res, nb, gd);
    check("after_abort_done", 32'(gd), 1);
    check("after_abort_res", 32'(res), 32'({1'b1, 1'b1, 8'h64}));

    // random sweep
    begin
      int unsigned bad;
      int unsigned miss;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic       rs;
      bad = 0; miss = 0;
      for (int unsigned i = 0; i < 1000; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        do_op(ra, rb, rc, rs, res, nb, gd);
        exp10 = model(ra, rb, rc, rs);
        if (!gd || nb != W) miss++;
        if (res !== exp10) begin
          bad++;
          if (bad <= 5)
            $display("FAIL rand_vec: a=%h b=%h cin=%b sub=%b got %h expected %h",
                     ra, rb, rc, rs, res, exp10);
        end
        @(negedge clk);
        if (bus.done) miss++;
      end
      check("rand_results", bad, 0);
      check("rand_done_once", miss, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
